seg_scan_controller: RTL and testbench

//  Time-multiplexes one shared hex-to-7-segment decoder (bto7s) across NUM_DIGITS

---
 rtl/seg_scan_controller.sv | 134 +++++++++++++
 tb/tb_seg_scan_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// Time-multiplexed 7-segment scanner: one shared decoder, per-digit dead time,
// frame-coherent input snapshot, blanking and leading-zero suppression.
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int COUNT_PERIOD = 100_000,
  parameter int DEAD_CYCLES  = 1_000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en_in,
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_out
);

  localparam int CW = $clog2(COUNT_PERIOD);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {DEAD, ON} slot_t;

  slot_t                   state, state_nxt;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    shadow_lz;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    allz;
  logic                    cnt_last;
  logic                    idx_last;
  logic                    frame_start;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [6:0]              cat_nxt;
  logic                    dp_nxt;

  // Active-high segment pattern, bit 0 = segment a.
  function automatic logic [6:0] bto7s(input logic [3:0] x);
    case (x)
      4'h0: bto7s = 7'h3F;
      4'h1: bto7s = 7'h06;
      4'h2: bto7s = 7'h5B;
      4'h3: bto7s = 7'h4F;
      4'h4: bto7s = 7'h66;
      4'h5: bto7s = 7'h6D;
      4'h6: bto7s = 7'h7D;
      4'h7: bto7s = 7'h07;
      4'h8: bto7s = 7'h7F;
      4'h9: bto7s = 7'h6F;
      4'hA: bto7s = 7'h77;
      4'hB: bto7s = 7'h7C;
      4'hC: bto7s = 7'h39;
      4'hD: bto7s = 7'h5E;
      4'hE: bto7s = 7'h79;
      default: bto7s = 7'h71;
    endcase
  endfunction

  assign cnt_last    = (cnt == CW'(COUNT_PERIOD - 1));
  assign idx_last    = (idx == IW'(NUM_DIGITS - 1));
  assign frame_start = (cnt == '0) && (idx == '0);
  assign nibble      = shadow_val[int'(idx)*4 +: 4];

  // Walk from the most significant digit down; digit 0 always survives.
  always_comb begin
    allz     = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      allz        = allz & (shadow_val[4*i +: 4] == 4'h0);
      lz_blank[i] = shadow_lz & allz & (i != 0);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= DEAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    an_nxt    = '1;
    cat_nxt   = 7'h7F;
    dp_nxt    = 1'b1;
    case (state)
      DEAD:    if (cnt == CW'(DEAD_CYCLES - 1)) state_nxt = ON;
      ON:      if (cnt_last) state_nxt = DEAD;
      default: state_nxt = DEAD;
    endcase
    if (state == ON && !shadow_blank[idx] && !lz_blank[idx]) begin
      an_nxt  = ~(NUM_DIGITS'(1) << idx);
      cat_nxt = ~bto7s(nibble);
      dp_nxt  = ~shadow_dp[idx];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt          <= '0;
      idx          <= '0;
      shadow_val   <= '0;
      shadow_blank <= '0;
      shadow_dp    <= '0;
      shadow_lz    <= 1'b0;
      an_out       <= '1;
      cat_out      <= 7'h7F;
      dp_out       <= 1'b1;
      frame_out    <= 1'b0;
    end else begin
      if (cnt_last) begin
        cnt <= '0;
        idx <= idx_last ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Shadow only reloads in the dead time of digit 0, so a frame never tears.
      if (frame_start) begin
        shadow_val   <= val_in;
        shadow_blank <= blank_in;
        shadow_dp    <= dp_in;
        shadow_lz    <= lz_en_in;
      end
      an_out    <= an_nxt;
      cat_out   <= cat_nxt;
      dp_out    <= dp_nxt;
      frame_out <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with N=4, P=10, D=2; samples on the falling edge.
module tb_seg_scan_controller;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] val_in;
  logic [3:0]  blank_in;
  logic [3:0]  dp_in;
  logic        lz_en_in;
  logic [6:0]  cat_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_out;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  // Active-low cathode patterns for hex 0..F, bit 0 = segment a.
  logic [6:0] seg_al [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_controller #(.NUM_DIGITS(4), .COUNT_PERIOD(10), .DEAD_CYCLES(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .val_in(val_in), .blank_in(blank_in),
    .dp_in(dp_in), .lz_en_in(lz_en_in), .cat_out(cat_out), .dp_out(dp_out),
    .an_out(an_out), .frame_out(frame_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(negedge clk_in);
    cyc = cyc + 1;
  endtask

  // Apply inputs, pulse reset, and release mid-cycle so the current cycle is cycle 0.
  task automatic start(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d,
                       input logic lz);
    val_in = v; blank_in = b; dp_in = d; lz_en_in = lz;
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; val_in = '0; blank_in = '0; dp_in = '0; lz_en_in = 1'b0;
    #2;
    n_tot++; if (an_out !== 4'hF) $display("FAIL reset_an got=%h exp=F", an_out); else n_pass++;
    n_tot++; if (cat_out !== 7'h7F) $display("FAIL reset_cat got=%h exp=7f", cat_out); else n_pass++;
    n_tot++; if (dp_out !== 1'b1) $display("FAIL reset_dp got=%b exp=1", dp_out); else n_pass++;
    n_tot++; if (frame_out !== 1'b0) $display("FAIL reset_frame got=%b exp=0", frame_out); else n_pass++;
  endtask

  task automatic test_basic();
    logic [3:0] ea;
    logic [6:0] ec;
    start(16'h1234, 4'h0, 4'h0, 1'b0);
    while (cyc <= 40) begin
      ea = 4'hF; ec = 7'h7F;
      if (cyc >= 3 && cyc <= 10)       begin ea = 4'hE; ec = 7'h19; end
      else if (cyc >= 13 && cyc <= 20) begin ea = 4'hD; ec = 7'h30; end
      else if (cyc >= 23 && cyc <= 30) begin ea = 4'hB; ec = 7'h24; end
      else if (cyc >= 33 && cyc <= 40) begin ea = 4'h7; ec = 7'h79; end
      n_tot++; if (an_out !== ea) $display("FAIL basic_an cyc=%0d got=%h exp=%h", cyc, an_out, ea); else n_pass++;
      n_tot++; if (cat_out !== ec) $display("FAIL basic_cat cyc=%0d got=%h exp=%h", cyc, cat_out, ec); else n_pass++;
      n_tot++; if (dp_out !== 1'b1) $display("FAIL basic_dp cyc=%0d got=%b exp=1", cyc, dp_out); else n_pass++;
      n_tot++; if (frame_out !== (cyc == 1)) $display("FAIL basic_frame cyc=%0d got=%b exp=%b", cyc, frame_out, cyc == 1); else n_pass++;
      tick();
    end
  endtask

  task automatic test_frame_coherent();
    logic [15:0] cur;
    logic [3:0]  ea;
    logic [6:0]  ec;
    int k, pos, dig;
    start(16'h1234, 4'h0, 4'h0, 1'b0);
    while (cyc <= 80) begin
      if (cyc == 15) val_in = 16'hABCD;
      ea = 4'hF; ec = 7'h7F;
      if (cyc >= 1) begin
        k = cyc - 1; pos = k % 10; dig = (k / 10) % 4;
        cur = (k >= 40) ? 16'hABCD : 16'h1234;
        if (pos >= 2) begin
          ea = ~(4'b0001 << dig);
          ec = seg_al[cur[dig*4 +: 4]];
        end
      end
      n_tot++; if (an_out !== ea) $display("FAIL coh_an cyc=%0d got=%h exp=%h", cyc, an_out, ea); else n_pass++;
      n_tot++; if (cat_out !== ec) $display("FAIL coh_cat cyc=%0d got=%h exp=%h", cyc, cat_out, ec); else n_pass++;
      n_tot++; if (frame_out !== (cyc == 1 || cyc == 41)) $display("FAIL coh_frame cyc=%0d got=%b", cyc, frame_out); else n_pass++;
      tick();
    end
  endtask

  task automatic test_lz();
    logic [3:0] ea;
    logic [6:0] ec;
    int k, pos, dig;
    start(16'h0050, 4'h0, 4'h0, 1'b1);
    while (cyc <= 40) begin
      ea = 4'hF; ec = 7'h7F;
      if (cyc >= 1) begin
        k = cyc - 1; pos = k % 10; dig = (k / 10) % 4;
        if (pos >= 2 && dig == 0) begin ea = 4'hE; ec = 7'h40; end
        if (pos >= 2 && dig == 1) begin ea = 4'hD; ec = 7'h12; end
      end
      n_tot++; if (an_out !== ea) $display("FAIL lz_an cyc=%0d got=%h exp=%h", cyc, an_out, ea); else n_pass++;
      n_tot++; if (cat_out !== ec) $display("FAIL lz_cat cyc=%0d got=%h exp=%h", cyc, cat_out, ec); else n_pass++;
      tick();
    end
  endtask

  task automatic test_blank_dp();
    logic [3:0] ea;
    logic [6:0] ec;
    logic       ed;
    int k;
    start(16'h0000, 4'h0, 4'h0, 1'b1);
    while (cyc <= 40) begin
      k = cyc - 1;
      ea = (cyc >= 3 && cyc <= 10) ? 4'hE : 4'hF;
      ec = (cyc >= 3 && cyc <= 10) ? 7'h40 : 7'h7F;
      n_tot++; if (an_out !== ea) $display("FAIL zero_an cyc=%0d got=%h exp=%h k=%0d", cyc, an_out, ea, k); else n_pass++;
      n_tot++; if (cat_out !== ec) $display("FAIL zero_cat cyc=%0d got=%h exp=%h", cyc, cat_out, ec); else n_pass++;
      tick();
    end
    start(16'h0000, 4'b0001, 4'h0, 1'b1);
    while (cyc <= 40) begin
      n_tot++; if (an_out !== 4'hF) $display("FAIL blank_an cyc=%0d got=%h exp=F", cyc, an_out); else n_pass++;
      tick();
    end
    start(16'h0000, 4'h0, 4'b0100, 1'b0);
    while (cyc <= 40) begin
      ed = !(cyc >= 23 && cyc <= 30);
      n_tot++; if (dp_out !== ed) $display("FAIL dp_out cyc=%0d got=%b exp=%b", cyc, dp_out, ed); else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ea;
    int k;
    start(16'h1234, 4'h0, 4'h0, 1'b0);
    while (cyc < 6) tick();
    n_tot++; if (an_out !== 4'hE) $display("FAIL mid_pre_an got=%h exp=E", an_out); else n_pass++;
    rst_in = 1'b1;
    #1;
    n_tot++; if (an_out !== 4'hF) $display("FAIL mid_an got=%h exp=F", an_out); else n_pass++;
    n_tot++; if (cat_out !== 7'h7F) $display("FAIL mid_cat got=%h exp=7f", cat_out); else n_pass++;
    n_tot++; if (dp_out !== 1'b1) $display("FAIL mid_dp got=%b exp=1", dp_out); else n_pass++;
    @(negedge clk_in);
    rst_in = 1'b0;
    cyc = 0;
    while (cyc <= 40) begin
      k = cyc - 1;
      ea = 4'hF;
      if (cyc >= 1 && (k % 10) >= 2) ea = ~(4'b0001 << ((k / 10) % 4));
      n_tot++; if (an_out !== ea) $display("FAIL mid_rel_an cyc=%0d got=%h exp=%h", cyc, an_out, ea); else n_pass++;
      n_tot++; if (frame_out !== (cyc == 1)) $display("FAIL mid_rel_frame cyc=%0d got=%b", cyc, frame_out); else n_pass++;
      tick();
    end
  endtask

  task automatic test_sweep();
    for (int x = 0; x < 16; x++) begin
      start(16'(x), 4'h0, 4'h0, 1'b0);
      while (cyc <= 10) begin
        n_tot++; if ($countones(~an_out) > 1) $display("FAIL sweep_onehot x=%0d cyc=%0d got=%h", x, cyc, an_out); else n_pass++;
        if (cyc >= 3) begin
          n_tot++; if (an_out !== 4'hE) $display("FAIL sweep_an x=%0d cyc=%0d got=%h exp=E", x, cyc, an_out); else n_pass++;
          n_tot++; if (cat_out !== seg_al[x]) $display("FAIL sweep_cat x=%0d cyc=%0d got=%h exp=%h", x, cyc, cat_out, seg_al[x]); else n_pass++;
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_coherent();
    test_lz();
    test_blank_dp();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
